regbank16_8: RTL and testbench

Eight-entry, 16-bit write-side register bank. It is the storage and write-decode counterpart of the 8:1 16-bit read mux. A single write port steers one 16-bit word into one of eight registers selected by a 3-bit index. All eight registers are presented in parallel to the read-side mux. Per-entry valid flags track which entries have been written since reset or the last clear.

---
 rtl/regbank16_8.sv | 77 +++++++
 tb/tb_regbank16_8.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regbank16_8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regbank16_8 : eight-entry 16-bit write-side register bank        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module regbank16_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [15:0] wr_data,
  input  logic        clr,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4,
  output logic [15:0] out5,
  output logic [15:0] out6,
  output logic [15:0] out7,
  output logic [7:0]  valid,
  output logic        wr_ack,
  output logic [2:0]  last_sel
);

  localparam int DEPTH = 8;

  logic [15:0] entry [DEPTH];
  logic [7:0]  wr_onehot;

  // Index is only decoded under wr_en, so an unknown wr_sel while idle
  // can never reach any entry enable.
  always_comb begin
    wr_onehot = 8'h00;
    if (wr_en) begin
      wr_onehot[wr_sel] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          entry[gi] <= 16'h0000;
          valid[gi] <= 1'b0;
        end else if (wr_onehot[gi]) begin
          entry[gi] <= wr_data;
          valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ack   <= 1'b0;
      last_sel <= 3'd0;
    end else begin
      wr_ack <= wr_en;
      if (wr_en) begin
        last_sel <= wr_sel;
      end
    end
  end

  assign out0 = entry[0];
  assign out1 = entry[1];
  assign out2 = entry[2];
  assign out3 = entry[3];
  assign out4 = entry[4];
  assign out5 = entry[5];
  assign out6 = entry[6];
  assign out7 = entry[7];

endmodule
`default_nettype wire

// File: tb/tb_regbank16_8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_regbank16_8 : scoreboard bench for regbank16_8                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_regbank16_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic        clr;
  logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  valid;
  logic        wr_ack;
  logic [2:0]  last_sel;

  regbank16_8 dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr(clr),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .valid(valid), .wr_ack(wr_ack), .last_sel(last_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] regs;
    logic [7:0]   vld;
    logic [2:0]   last;
    logic         ack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain array of words plus the bookkeeping fields.
  logic [15:0] m_regs [8];
  logic [7:0]  m_vld;
  logic [2:0]  m_last;
  logic        m_ack;

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_regs[i];
    return f;
  endfunction

  function automatic logic [127:0] dut_flat();
    return {out7, out6, out5, out4, out3, out2, out1, out0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One clock cycle of stimulus; called right after a falling edge.
  task automatic drive(input logic r, input logic we, input logic [2:0] sel,
                       input logic [15:0] d, input logic c);
    exp_t e;
    rst_n = r; wr_en = we; wr_sel = sel; wr_data = d; clr = c;
    #1;
    // Before the edge the outputs must still show the stored state.
    check("no_bypass", {{0{1'b0}}, dut_flat()}, model_flat());
    if (!r || c) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_vld = 8'h00; m_last = 3'd0; m_ack = 1'b0;
    end else if (we) begin
      m_regs[sel] = d;
      m_vld[sel]  = 1'b1;
      m_last      = sel;
      m_ack       = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    e.regs = model_flat(); e.vld = m_vld; e.last = m_last; e.ack = m_ack;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("entries", dut_flat(), e.regs);
        check("valid", {120'd0, valid}, {120'd0, e.vld});
        check("last_sel", {125'd0, last_sel}, {125'd0, e.last});
        check("wr_ack", {127'd0, wr_ack}, {127'd0, e.ack});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ack_run;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_vld = 8'h00; m_last = 3'd0; m_ack = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0; clr = 1'b0;
    @(negedge clk);
    // Reset with a write pending
    drive(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0);
    drive(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0);
    // Walk all entries on consecutive cycles
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 3'(i), 16'(16'h1111 * i), 1'b0);
    // Clear has priority over a simultaneous write
    drive(1'b1, 1'b1, 3'd3, 16'h1234, 1'b1);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
    // Back-to-back same index
    drive(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b0);
    drive(1'b1, 1'b1, 3'd2, 16'h5555, 1'b0);
    // Boundary data; entry 0 first holds a non-zero value so old/new differ
    drive(1'b1, 1'b1, 3'd0, 16'h0F0F, 1'b0);
    drive(1'b1, 1'b1, 3'd7, 16'hFFFF, 1'b0);
    drive(1'b1, 1'b1, 3'd0, 16'h8000, 1'b0);
    // Idle hold with toggling (and unknown) write index/data
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b0, (i == 4) ? 3'bxxx : 3'($urandom_range(0, 7)),
            16'($urandom), 1'b0);
    // Sustained writes: ack must stay high continuously
    ack_run = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
      if (wr_ack) ack_run++;
    end
    check("ack_run", 128'(ack_run), 128'd6);
    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 99);
      drive((k < 3) ? 1'b0 : 1'b1, ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 16'($urandom), (k >= 3 && k < 7));
    end
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
